// File: rtl/led_pattern_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
// Optional feature macro used by this slice: LED_PATTERN_SEQ_TICK_SYNC_EN.
package led_seq_pkg;

   typedef enum logic [1:0] {
      MODE_ROT_L = 2'b00,
      MODE_ROT_R = 2'b01,
      MODE_BNC   = 2'b10,
      MODE_COUNT = 2'b11
   } mode_t;

   typedef enum logic [2:0] {
      IDLE,
      ROT_L,
      ROT_R,
      BNC_L,
      BNC_R,
      COUNT
   } state_t;

   // Tick history resets high so a tick already high at reset release is not a step
   localparam logic TICK_Q_RST = 1'b1;

endpackage

// File: rtl/led_pattern_seq_if.sv
// Control/status bundle between the tick source/controller and the LED sequencer.
interface led_pattern_seq_if #(
   parameter int unsigned WIDTH = 8
);

   logic             tick;
   logic             run;
   logic [1:0]       mode;
   logic [WIDTH-1:0] leds;
   logic             step;
   logic             wrap;

   modport master (
      output tick, run, mode,
      input  leds, step, wrap
   );

   modport slave (
      input  tick, run, mode,
      output leds, step, wrap
   );

endinterface

// File: rtl/led_pattern_seq_tick_edge_detect.sv
// Rising-edge detector for the tick enable level.
// With LED_PATTERN_SEQ_TICK_SYNC_EN defined, tick first passes a 2-flop
// synchronizer (adds two cycles of step latency).
module tick_edge_detect
   import led_seq_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic tick_i,
   output logic tick_rise_o
);

   logic tick_s;
   logic tick_q;

`ifdef LED_PATTERN_SEQ_TICK_SYNC_EN
   logic sync1_q;
   logic sync2_q;

   // Two-stage synchronizer, reset high like the history register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= TICK_Q_RST;
         sync2_q <= TICK_Q_RST;
      end else begin
         sync1_q <= tick_i;
         sync2_q <= sync1_q;
      end
   end

   assign tick_s = sync2_q;
`else
   assign tick_s = tick_i;
`endif

   // Tick history, updated every cycle regardless of sequencer state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_q <= TICK_Q_RST;
      end else begin
         tick_q <= tick_s;
      end
   end

   assign tick_rise_o = tick_s & ~tick_q;

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: each tick rising edge advances a rotate-left,
// rotate-right, bounce or binary-count pattern; emits step/wrap pulses.
// Optional macro: LED_PATTERN_SEQ_TICK_SYNC_EN (tick synchronizer in tick_edge_detect).
module led_pattern_seq
   import led_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   led_pattern_seq_if.slave   bus
);

   localparam logic [WIDTH-1:0] LSB_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] leds_q,  leds_d;
   logic             step_q,  step_d;
   logic             wrap_q,  wrap_d;
   logic             tick_rise;

   tick_edge_detect u_tick_edge (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick_i      (bus.tick),
      .tick_rise_o (tick_rise)
   );

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         leds_q  <= '0;
         step_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         leds_q  <= leds_d;
         step_q  <= step_d;
         wrap_q  <= wrap_d;
      end
   end

   // Next-state, next-pattern and pulse generation
   always_comb begin
      state_d = state_q;
      leds_d  = leds_q;
      step_d  = 1'b0;
      wrap_d  = 1'b0;

      if (state_q == IDLE) begin
         leds_d = '0;
         // Mode is only sampled here; a tick rise on this edge is discarded
         if (bus.run) begin
            case (mode_t'(bus.mode))
               MODE_ROT_L: begin state_d = ROT_L; leds_d = LSB_ONE; end
               MODE_ROT_R: begin state_d = ROT_R; leds_d = MSB_ONE; end
               MODE_BNC:   begin state_d = BNC_L; leds_d = LSB_ONE; end
               MODE_COUNT: begin state_d = COUNT; leds_d = '0;      end
            endcase
         end
      end else if (!bus.run) begin
         state_d = IDLE;
         leds_d  = '0;
      end else if (tick_rise) begin
         step_d = 1'b1;
         case (state_q)
            ROT_L: begin
               leds_d = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
               wrap_d = leds_q[WIDTH-1];
            end
            ROT_R: begin
               leds_d = {leds_q[0], leds_q[WIDTH-1:1]};
               wrap_d = leds_q[0];
            end
            BNC_L: begin
               leds_d = leds_q << 1;
               if (leds_d == MSB_ONE) begin
                  state_d = BNC_R;
               end
            end
            BNC_R: begin
               leds_d = leds_q >> 1;
               if (leds_d == LSB_ONE) begin
                  state_d = BNC_L;
                  wrap_d  = 1'b1;
               end
            end
            COUNT: begin
               leds_d = leds_q + LSB_ONE;
               wrap_d = &leds_q;
            end
            default: begin
               state_d = IDLE;
               leds_d  = '0;
               step_d  = 1'b0;
            end
         endcase
      end
   end

   assign bus.leds = leds_q;
   assign bus.step = step_q;
   assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq (WIDTH=8) against a step-count model.
module tb_led_pattern_seq;

   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int unsigned vecs = 0;
   int unsigned errs = 0;

   led_pattern_seq_if #(.WIDTH(W)) bus ();

   led_pattern_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // LED value after k steps from the seed of a given mode
   function automatic logic [W-1:0] pattern(input logic [1:0] m, input int unsigned k);
      int unsigned p;
      case (m)
         2'b00: pattern = W'(1) << (k % W);
         2'b01: pattern = W'(1) << (W - 1 - (k % W));
         2'b10: begin
            p = k % (2 * (W - 1));
            pattern = W'(1) << ((p < W) ? p : (2 * (W - 1) - p));
         end
         default: pattern = W'(k % (1 << W));
      endcase
   endfunction

   function automatic int unsigned period(input logic [1:0] m);
      case (m)
         2'b00, 2'b01: period = W;
         2'b10:        period = 2 * (W - 1);
         default:      period = 1 << W;
      endcase
   endfunction

   logic         m_active;
   logic [1:0]   m_mode;
   int unsigned  m_k;
   logic         m_tprev, m_s1, m_s2;
   logic [W-1:0] exp_leds;
   logic         exp_step, exp_wrap;
   logic         m_t, m_rise;

`ifdef LED_PATTERN_SEQ_TICK_SYNC_EN
   assign m_t = m_s2;
`else
   assign m_t = bus.tick;
`endif
   assign m_rise = m_t & ~m_tprev;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0; m_mode <= 2'b00; m_k <= 0;
         m_tprev <= 1'b1; m_s1 <= 1'b1; m_s2 <= 1'b1;
         exp_leds <= '0; exp_step <= 1'b0; exp_wrap <= 1'b0;
      end else begin
         m_tprev <= m_t;
         m_s1 <= bus.tick;
         m_s2 <= m_s1;
         exp_step <= 1'b0;
         exp_wrap <= 1'b0;
         if (!m_active) begin
            if (bus.run) begin
               m_active <= 1'b1; m_mode <= bus.mode; m_k <= 0;
               exp_leds <= pattern(bus.mode, 0);
            end else begin
               exp_leds <= '0;
            end
         end else if (!bus.run) begin
            m_active <= 1'b0;
            exp_leds <= '0;
         end else if (m_rise) begin
            m_k <= m_k + 1;
            exp_leds <= pattern(m_mode, m_k + 1);
            exp_step <= 1'b1;
            exp_wrap <= ((m_k + 1) % period(m_mode)) == 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic clk1();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; bus.tick = 1'b1; bus.run = 1'b0; bus.mode = 2'b00;
      repeat (3) clk1();
      vecs++;
      if ({bus.leds, bus.step, bus.wrap} !== {W'(0), 2'b00}) begin
         errs++; $display("FAIL reset_state got leds=%h step=%b wrap=%b want 00/0/0", bus.leds, bus.step, bus.wrap);
      end
      rst_n = 1'b1; bus.run = 1'b1;
      clk1();
      vecs++;
      if ({bus.leds, bus.step} !== {W'(1), 1'b0}) begin
         errs++; $display("FAIL seed_after_reset got leds=%h step=%b want 01/0", bus.leds, bus.step);
      end
      for (int c = 0; c < 8; c++) begin
         bus.tick = (c == 3) ? 1'b0 : 1'b1;
         clk1();
         vecs++;
         if ({bus.leds, bus.step, bus.wrap} !== {exp_leds, exp_step, exp_wrap}) begin
            errs++; $display("FAIL first_step c=%0d got %h/%b/%b want %h/%b/%b", c, bus.leds, bus.step, bus.wrap, exp_leds, exp_step, exp_wrap);
         end
         if (c < 3 && bus.step !== 1'b0) begin
            errs++; $display("FAIL held_tick_at_reset c=%0d got step=%b want 0", c, bus.step);
         end
      end
      vecs++;
      if ({bus.leds, bus.step} !== {W'(2), 1'b0}) begin
         errs++; $display("FAIL first_step_value got leds=%h step=%b want 02/0", bus.leds, bus.step);
      end
      bus.tick = 1'b0;
      clk1();
   endtask

   task automatic test_pattern(input logic [1:0] mode, input int unsigned pulses, input logic [W-1:0] seed);
      int unsigned wraps = 0;
      int unsigned steps = 0;
      bus.tick = 1'b0; bus.run = 1'b0;
      repeat (2) clk1();
      bus.run = 1'b1; bus.mode = mode;
      clk1();
      vecs++;
      if ({bus.leds, bus.step} !== {seed, 1'b0}) begin
         errs++; $display("FAIL seed_m%0d got leds=%h step=%b want %h/0", mode, bus.leds, bus.step, seed);
      end
      for (int p = 0; p < int'(pulses); p++) begin
         int unsigned hi = $urandom_range(1, 4);
         int unsigned lo = $urandom_range(1, 3);
         if (mode == 2'b11 && p == 100) bus.mode = 2'b00;
         for (int c = 0; c < int'(hi + lo); c++) begin
            bus.tick = (c < int'(hi));
            clk1();
            vecs++;
            if ({bus.leds, bus.step, bus.wrap} !== {exp_leds, exp_step, exp_wrap}) begin
               errs++; $display("FAIL pattern_m%0d p=%0d got %h/%b/%b want %h/%b/%b", mode, p, bus.leds, bus.step, bus.wrap, exp_leds, exp_step, exp_wrap);
            end
            if (bus.wrap === 1'b1) wraps++;
            if (bus.step === 1'b1) steps++;
         end
      end
      bus.tick = 1'b0;
      repeat (4) begin
         clk1();
         if (bus.wrap === 1'b1) wraps++;
         if (bus.step === 1'b1) steps++;
      end
      vecs++;
      if (wraps !== 1 || steps !== pulses || bus.leds !== seed) begin
         errs++; $display("FAIL cycle_m%0d got wraps=%0d steps=%0d leds=%h want 1/%0d/%h", mode, wraps, steps, bus.leds, pulses, seed);
      end
   endtask

   task automatic test_simultaneous();
      bus.tick = 1'b0; bus.run = 1'b0;
      repeat (2) clk1();
      bus.run = 1'b1; bus.mode = 2'b00;
      clk1();
      repeat (2) begin
         bus.tick = 1'b1; clk1(); clk1();
         bus.tick = 1'b0; clk1();
      end
      repeat (3) clk1();
      bus.run = 1'b0; bus.tick = 1'b1;
      clk1();
      vecs++;
      if ({bus.leds, bus.step, bus.wrap} !== {W'(0), 2'b00} || exp_leds !== W'(0)) begin
         errs++; $display("FAIL stop_on_tick got %h/%b/%b want 00/0/0", bus.leds, bus.step, bus.wrap);
      end
      bus.tick = 1'b0;
      clk1();
      bus.run = 1'b1; bus.tick = 1'b1;
      clk1();
      vecs++;
      if ({bus.leds, bus.step, bus.wrap} !== {W'(1), 2'b00}) begin
         errs++; $display("FAIL start_on_tick got %h/%b/%b want 01/0/0", bus.leds, bus.step, bus.wrap);
      end
      for (int c = 0; c < 5; c++) begin
         clk1();
         vecs++;
         if ({bus.leds, bus.step, bus.wrap} !== {exp_leds, exp_step, exp_wrap}) begin
            errs++; $display("FAIL after_start c=%0d got %h/%b/%b want %h/%b/%b", c, bus.leds, bus.step, bus.wrap, exp_leds, exp_step, exp_wrap);
         end
      end
      bus.tick = 1'b0;
      clk1();
   endtask

   task automatic test_async_reset();
      bus.tick = 1'b0; bus.run = 1'b0;
      repeat (2) clk1();
      bus.run = 1'b1; bus.mode = 2'b00;
      clk1();
      repeat (4) begin
         bus.tick = 1'b1; clk1();
         bus.tick = 1'b0; clk1(); clk1();
      end
      repeat (3) clk1();
      vecs++;
      if (bus.leds !== W'(8'h10)) begin
         errs++; $display("FAIL pre_reset got leds=%h want 10", bus.leds);
      end
      #2 rst_n = 1'b0;
      #1;
      vecs++;
      if ({bus.leds, bus.step, bus.wrap} !== {W'(0), 2'b00}) begin
         errs++; $display("FAIL async_reset got %h/%b/%b want 00/0/0", bus.leds, bus.step, bus.wrap);
      end
      clk1();
      rst_n = 1'b1;
      clk1();
      vecs++;
      if ({bus.leds, bus.step} !== {W'(1), 1'b0}) begin
         errs++; $display("FAIL restart_seed got leds=%h step=%b want 01/0", bus.leds, bus.step);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 2) == 0) bus.tick = ~bus.tick;
         bus.run = ($urandom_range(0, 31) != 0);
         if ($urandom_range(0, 7) == 0) bus.mode = 2'($urandom_range(0, 3));
         clk1();
         vecs++;
         if ({bus.leds, bus.step, bus.wrap} !== {exp_leds, exp_step, exp_wrap}) begin
            errs++; $display("FAIL random c=%0d got %h/%b/%b want %h/%b/%b", c, bus.leds, bus.step, bus.wrap, exp_leds, exp_step, exp_wrap);
         end
      end
   endtask

   initial begin
      bus.tick = 1'b1; bus.run = 1'b0; bus.mode = 2'b00;
      test_reset();
      test_pattern(2'b00, 8, W'(8'h01));
      test_pattern(2'b01, 8, W'(8'h80));
      test_pattern(2'b10, 14, W'(8'h01));
      test_pattern(2'b11, 256, W'(8'h00));
      test_simultaneous();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
- Consumes the periodic enable level produced by the clock-enable stage.
- Each rising edge of that level advances an LED pattern by one step. Patterns: rotate left, rotate right, bounce, or binary count.
- Drives the board LED bank and emits one-cycle step and wrap pulses for downstream status logic.
- Runs in the same clock domain as the clock-enable stage.

Parameters:
- WIDTH, 8: number of LEDs / pattern register width; legal range 2..32.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- tick  input  1  enable level from the clock-enable stage; each 0->1 transition is one step request.
- run  input  1  level; 1 = sequence active, 0 = idle with LEDs dark.
- mode  input  2  pattern select: 00 rotate left, 01 rotate right, 10 bounce, 11 binary count.
- leds  output  WIDTH  registered LED drive.
- step  output  1  registered; high for exactly the one cycle in which leds takes a stepped value.
- wrap  output  1  registered; high for exactly one cycle when a pattern completes a full cycle. Coincides with step.

Behaviour:
- Reset is asynchronous active-low; one clock; reset is asynchronous and active-low.
- Reset values: leds=0, step=0, wrap=0, state=IDLE, tick history register tick_q=1.
  - tick_q=1 suppresses a spurious step when tick is already high at reset release.
- Edge detect: tick_rise = tick & ~tick_q, and tick_q <= tick every cycle in every state.
- States: IDLE, ROT_L, ROT_R, BNC_L, BNC_R, COUNT.
- IDLE:
  - leds=0.
  - run=1 loads the seed on the next edge and enters the mode's state: 00->ROT_L, seed 1; 01->ROT_R, seed 1<<(WIDTH-1); 10->BNC_L, seed 1; 11->COUNT, seed 0.
  - Seed load is not a step; step=0.
- Mode is sampled only on the IDLE exit. Changes while running are ignored until the sequence returns to IDLE.
- Any running state with run=0: next edge goes to IDLE, leds=0, step=0, wrap=0.
- Running state with run=1 and tick_rise: on that same clock edge, leds takes its next value and step=1.
  - Latency: leds changes on the first edge that samples tick=1 after tick=0.
- Step rules:
  - ROT_L: rotate left by 1; wrap=1 when the MSB moves to the LSB.
  - ROT_R: rotate right by 1; wrap=1 when the LSB moves to the MSB.
  - BNC_L: shift left. When the new value is the MSB, go to BNC_R; no wrap.
  - BNC_R: shift right. When the new value is the LSB, go to BNC_L with wrap=1. Full cycle is 2*(WIDTH-1) steps.
  - COUNT: leds+1 modulo 2^WIDTH; wrap=1 on all-ones -> 0.
- Otherwise step=0 and wrap=0 every cycle.
- Simultaneous events:
  - run=1 and tick_rise on the IDLE exit edge: seed only, no step.
  - run=0 and tick_rise while running: go to IDLE, no step.
  - tick_rise while IDLE: discarded.
- Held tick: a tick held high for many cycles (250 ms pulses) produces one step only.
- Reset mid-operation: outputs clear immediately on rst_n falling, independent of clk. The sequence restarts from IDLE.

Optional Feature:
- Macro: LED_PATTERN_SEQ_TICK_SYNC_EN.
- Defined: tick passes through a 2-flop synchronizer (both flops reset to 1) before edge detection. Step latency grows by 2 cycles; all other rules are unchanged.
- Undefined: tick goes directly to the edge detect; the tick source must be synchronous to clk.

Decomposition:
- Package led_seq_pkg holds:
  - mode_t enum with MODE_ROT_L=2'b00, MODE_ROT_R=2'b01, MODE_BNC=2'b10, MODE_COUNT=2'b11.
  - state_t enum for the six states.
  - Constant TICK_Q_RST=1'b1.
- One sub-module, tick_edge_detect. It contains the optional synchronizer plus the tick_q register and outputs tick_rise. Everything else stays in led_pattern_seq.

Test Plan (WIDTH=8):
- Reset with tick=1, release, run=1, mode=00 -> leds=0x01 one edge later, step=0. No step until tick goes 0 then 1; then leds=0x02, step=1 for one cycle.
- mode=00, 8 tick pulses -> leds 0x02,0x04,...,0x80,0x01. wrap=1 only on the 0x80->0x01 step. Repeat with mode=01 from 0x80 -> wrap on 0x01->0x80.
- mode=10, 14 tick pulses -> 0x02..0x80 then 0x40..0x01. No wrap at 0x80; wrap=1 on the 14th step to 0x01.
- mode=11, 256 tick pulses -> leds increments each step, 0xFF->0x00 with wrap=1. Change mode to 00 mid-run -> counting continues.
- Running, run 1->0 on the same edge as tick 0->1 -> leds=0x00, step=0, state IDLE. run 0->1 on the same edge as a tick rise -> seed only, step=0.
- Running at leds=0x10, drop rst_n between clock edges -> leds=0x00, step=0, wrap=0 before the next posedge.
- Build with LED_PATTERN_SEQ_TICK_SYNC_EN -> every step lands 2 cycles later than in the undefined build for identical stimulus.
